bop_table_ctrl: RTL and testbench

BOP_TABLE_CTRL -- requirements
Module: bop_table_ctrl

---
 rtl/ariane_pkg.sv | 18 +
 rtl/bop_interval_table.sv | 60 ++++++
 rtl/bop_table_ctrl.sv | 137 +++++++++++++
 tb/tb_bop_table_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the bypass-on-pending interval table: slot layout and controller FSM state.
package ariane_pkg;

  // Slots store addresses at the widest supported width; narrower tables zero-extend.
  localparam int unsigned BOP_MAX_AW = 64;

  typedef struct packed {
    logic                  valid;
    logic [BOP_MAX_AW-1:0] start_addr;
    logic [BOP_MAX_AW-1:0] end_addr;
  } bop_entry_t;

  typedef enum logic {
    BOP_IDLE,
    BOP_FLUSH
  } bop_state_e;

endpackage

// File: rtl/bop_interval_table.sv
// Interval storage with one write port, one clear port and a combinational hit/first compare.
module bop_interval_table import ariane_pkg::*; #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned AW         = 32,
  localparam int unsigned IW        = $clog2(NR_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [AW-1:0] wstart_i,
  input  logic [AW-1:0] wend_i,
  input  logic          clr_i,
  input  logic [IW-1:0] caddr_i,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic          first_o
);

  bop_entry_t entries_q [NR_ENTRIES];

  logic [AW-1:0]         addr_next;
  logic [BOP_MAX_AW-1:0] addr_ext;
  logic [BOP_MAX_AW-1:0] next_ext;

  // Clearing only drops the valid bit; stale bounds are harmless once invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        entries_q[IW'(i)] <= '0;
      end
    end else if (clr_i) begin
      entries_q[caddr_i].valid <= 1'b0;
    end else if (we_i) begin
      entries_q[waddr_i] <= '{valid:      1'b1,
                              start_addr: BOP_MAX_AW'(wstart_i),
                              end_addr:   BOP_MAX_AW'(wend_i)};
    end
  end

  // The successor address wraps at AW bits before widening, so all-ones looks ahead to zero.
  assign addr_next = addr_i + AW'(1);
  assign addr_ext  = BOP_MAX_AW'(addr_i);
  assign next_ext  = BOP_MAX_AW'(addr_next);

  always_comb begin
    hit_o   = 1'b0;
    first_o = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (entries_q[IW'(i)].valid && (entries_q[IW'(i)].start_addr <= addr_ext) &&
          (addr_ext <= entries_q[IW'(i)].end_addr)) begin
        hit_o = 1'b1;
      end
      if (entries_q[IW'(i)].valid && (entries_q[IW'(i)].start_addr == next_ext)) begin
        first_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bop_table_ctrl.sv
// Interval table controller: arbitrates inserts, two lookup ports and flush onto one table access per cycle.
module bop_table_ctrl import ariane_pkg::*; #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned AW         = 32,
  localparam int unsigned IW        = $clog2(NR_ENTRIES),
  localparam int unsigned CW        = IW + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  logic [AW-1:0]      ins_start_i,
  input  logic [AW-1:0]      ins_end_i,
  input  logic [1:0]         lkp_valid_i,
  output logic [1:0]         lkp_ready_o,
  input  logic [1:0][AW-1:0] lkp_addr_i,
  output logic [1:0]         lkp_rsp_valid_o,
  output logic               lkp_hit_o,
  output logic               lkp_first_o,
  input  logic               flush_i,
  output logic               busy_o,
  output logic [CW-1:0]      count_o,
  output logic               ins_err_o
);

  bop_state_e    state_q;
  logic [IW-1:0] flush_cnt_q;
  logic [IW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          rr_ptr_q;
  logic [1:0]    rsp_valid_q;
  logic          hit_q;
  logic          first_q;
  logic          ins_err_q;

  logic          idle_free;
  logic          ins_acc;
  logic          ins_bad;
  logic          ins_wr;
  logic          lkp_open;
  logic [1:0]    grant;
  logic [AW-1:0] lkp_sel;
  logic          tbl_hit;
  logic          tbl_first;

  // Ready is forced low while reset is held, even though the state register already reads IDLE.
  assign idle_free = rst_ni && (state_q == BOP_IDLE) && !flush_i;
  assign ins_acc   = ins_valid_i && idle_free;
  assign ins_bad   = ins_start_i > ins_end_i;
  assign ins_wr    = ins_acc && !ins_bad;
  assign lkp_open  = idle_free && !ins_acc;

  always_comb begin
    grant = '0;
    if (lkp_open) begin
      if (&lkp_valid_i) begin
        grant[rr_ptr_q] = 1'b1;
      end else begin
        grant = lkp_valid_i;
      end
    end
  end

  assign lkp_sel = grant[1] ? lkp_addr_i[1] : lkp_addr_i[0];

  bop_interval_table #(
    .NR_ENTRIES(NR_ENTRIES),
    .AW        (AW)
  ) i_table (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ins_wr),
    .waddr_i (wr_ptr_q),
    .wstart_i(ins_start_i),
    .wend_i  (ins_end_i),
    .clr_i   (state_q == BOP_FLUSH),
    .caddr_i (flush_cnt_q),
    .addr_i  (lkp_sel),
    .hit_o   (tbl_hit),
    .first_o (tbl_first)
  );

  // After any grant the round-robin pointer lands on the port that was not served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOP_IDLE;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= '0;
      hit_q       <= 1'b0;
      first_q     <= 1'b0;
      ins_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      hit_q       <= (|grant) && tbl_hit;
      first_q     <= (|grant) && tbl_first;
      ins_err_q   <= ins_acc && ins_bad;
      if (|grant) begin
        rr_ptr_q <= grant[0];
      end
      case (state_q)
        BOP_IDLE: begin
          if (flush_i) begin
            state_q     <= BOP_FLUSH;
            flush_cnt_q <= '0;
          end else if (ins_wr) begin
            wr_ptr_q <= wr_ptr_q + IW'(1);
            if (count_q != CW'(NR_ENTRIES)) begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        BOP_FLUSH: begin
          flush_cnt_q <= flush_cnt_q + IW'(1);
          if (flush_cnt_q == IW'(NR_ENTRIES - 1)) begin
            state_q  <= BOP_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
          end
        end
        default: state_q <= BOP_IDLE;
      endcase
    end
  end

  assign ins_ready_o     = idle_free;
  assign lkp_ready_o     = grant;
  assign lkp_rsp_valid_o = rsp_valid_q;
  assign lkp_hit_o       = hit_q;
  assign lkp_first_o     = first_q;
  assign busy_o          = (state_q == BOP_FLUSH);
  assign count_o         = count_q;
  assign ins_err_o       = ins_err_q;

endmodule

// File: tb/tb_bop_table_ctrl.sv
// Directed bench for bop_table_ctrl: inserts, lookups, round-robin, wrap, flush and bad inserts.
module tb_bop_table_ctrl;

  localparam int unsigned NR_ENTRIES = 8;
  localparam int unsigned AW         = 32;
  localparam int unsigned CW         = $clog2(NR_ENTRIES) + 1;

  logic               clk_i;
  logic               rst_ni;
  logic               ins_valid_i;
  logic               ins_ready_o;
  logic [AW-1:0]      ins_start_i;
  logic [AW-1:0]      ins_end_i;
  logic [1:0]         lkp_valid_i;
  logic [1:0]         lkp_ready_o;
  logic [1:0][AW-1:0] lkp_addr_i;
  logic [1:0]         lkp_rsp_valid_o;
  logic               lkp_hit_o;
  logic               lkp_first_o;
  logic               flush_i;
  logic               busy_o;
  logic [CW-1:0]      count_o;
  logic               ins_err_o;

  int checks = 0;
  int errors = 0;

  bop_table_ctrl #(
    .NR_ENTRIES(NR_ENTRIES),
    .AW        (AW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ins_valid_i    (ins_valid_i),
    .ins_ready_o    (ins_ready_o),
    .ins_start_i    (ins_start_i),
    .ins_end_i      (ins_end_i),
    .lkp_valid_i    (lkp_valid_i),
    .lkp_ready_o    (lkp_ready_o),
    .lkp_addr_i     (lkp_addr_i),
    .lkp_rsp_valid_o(lkp_rsp_valid_o),
    .lkp_hit_o      (lkp_hit_o),
    .lkp_first_o    (lkp_first_o),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .count_o        (count_o),
    .ins_err_o      (ins_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; registered outputs are read at the next falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ins_valid_i = 1'b0;
    lkp_valid_i = 2'b00;
    flush_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic do_insert(input logic [AW-1:0] s, input logic [AW-1:0] e);
    ins_start_i = s;
    ins_end_i   = e;
    ins_valid_i = 1'b1;
    step();
    ins_valid_i = 1'b0;
  endtask

  task automatic do_lookup(input int port, input logic [AW-1:0] a);
    lkp_addr_i[port]  = a;
    lkp_valid_i[port] = 1'b1;
    step();
    lkp_valid_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ins_valid_i = 1'b1;
    ins_start_i = '0;
    ins_end_i = '0;
    lkp_valid_i = 2'b11;
    lkp_addr_i = '0;
    flush_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (ins_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ins_ready: got %0b expected 0", ins_ready_o); end
    checks++; if (lkp_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL rst_lkp_ready: got %b expected 00", lkp_ready_o); end
    checks++; if ({busy_o, ins_err_o, lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 6'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 000000", {busy_o, ins_err_o, lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    checks++; if (count_o !== CW'(0)) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", count_o); end
    @(negedge clk_i);
    ins_valid_i = 1'b0;
    lkp_valid_i = 2'b00;
    rst_ni = 1'b1;
    #1;
    checks++; if (ins_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %0b expected 1", ins_ready_o); end
    @(negedge clk_i);
  endtask

  task automatic test_basic_lookup();
    do_insert(32'h1000, 32'h1010);
    checks++; if (count_o !== CW'(1)) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", count_o); end
    do_lookup(0, 32'h1008);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b0110) begin errors++; $display("[TB] FAIL basic_inside: got %b expected 0110", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    do_lookup(0, 32'h0FFF);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b0101) begin errors++; $display("[TB] FAIL basic_first: got %b expected 0101", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    do_lookup(0, 32'h1011);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b0100) begin errors++; $display("[TB] FAIL basic_above: got %b expected 0100", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    do_lookup(1, 32'h1010);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b1010) begin errors++; $display("[TB] FAIL basic_end_edge: got %b expected 1010", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    do_lookup(1, 32'h1000);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b1010) begin errors++; $display("[TB] FAIL basic_start_edge: got %b expected 1010", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    step();
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b0000) begin errors++; $display("[TB] FAIL basic_idle_rsp: got %b expected 0000", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_insert(32'h2000 + 32'(i) * 32'h100, 32'h200F + 32'(i) * 32'h100);
    end
    checks++; if (count_o !== CW'(8)) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 8", count_o); end
    do_lookup(0, 32'h2000);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b010) begin errors++; $display("[TB] FAIL wrap_oldest_gone: got %b expected 010", {lkp_rsp_valid_o, lkp_hit_o}); end
    do_lookup(0, 32'h2805);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b011) begin errors++; $display("[TB] FAIL wrap_ninth_hit: got %b expected 011", {lkp_rsp_valid_o, lkp_hit_o}); end
    do_lookup(0, 32'h27FF);
    checks++; if ({lkp_hit_o, lkp_first_o} !== 2'b01) begin errors++; $display("[TB] FAIL wrap_ninth_first: got %b expected 01", {lkp_hit_o, lkp_first_o}); end
    do_lookup(1, 32'h2105);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b101) begin errors++; $display("[TB] FAIL wrap_second_kept: got %b expected 101", {lkp_rsp_valid_o, lkp_hit_o}); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant;
    lkp_addr_i[0] = 32'h2105;
    lkp_addr_i[1] = 32'h3000;
    lkp_valid_i   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (lkp_ready_o !== exp_grant) begin errors++; $display("[TB] FAIL rr_ready_%0d: got %b expected %b", i, lkp_ready_o, exp_grant); end
      step();
      checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== {exp_grant, exp_grant[0]}) begin errors++; $display("[TB] FAIL rr_rsp_%0d: got %b expected %b", i, {lkp_rsp_valid_o, lkp_hit_o}, {exp_grant, exp_grant[0]}); end
    end
    lkp_valid_i = 2'b00;
  endtask

  task automatic test_back_to_back();
    ins_start_i   = 32'h5000;
    ins_end_i     = 32'h5010;
    ins_valid_i   = 1'b1;
    lkp_addr_i[0] = 32'h5008;
    lkp_valid_i   = 2'b01;
    #1;
    checks++; if ({ins_ready_o, lkp_ready_o} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected 100", {ins_ready_o, lkp_ready_o}); end
    step();
    ins_valid_i = 1'b0;
    checks++; if (lkp_rsp_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL b2b_no_rsp: got %b expected 00", lkp_rsp_valid_o); end
    #1;
    checks++; if (lkp_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL b2b_lkp_ready: got %b expected 01", lkp_ready_o); end
    step();
    lkp_valid_i = 2'b00;
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b011) begin errors++; $display("[TB] FAIL b2b_hit_new: got %b expected 011", {lkp_rsp_valid_o, lkp_hit_o}); end
    checks++; if (count_o !== CW'(8)) begin errors++; $display("[TB] FAIL b2b_count_sat: got %0d expected 8", count_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_insert(32'h6000 + 32'(i) * 32'h100, 32'h600F + 32'(i) * 32'h100);
    end
    checks++; if (count_o !== CW'(5)) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", count_o); end
    lkp_addr_i[0] = 32'h6005;
    lkp_valid_i   = 2'b01;
    step();
    lkp_valid_i = 2'b00;
    flush_i     = 1'b1;
    #1;
    checks++; if (ins_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready: got %0b expected 0", ins_ready_o); end
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b011) begin errors++; $display("[TB] FAIL flush_inflight_rsp: got %b expected 011", {lkp_rsp_valid_o, lkp_hit_o}); end
    step();
    flush_i     = 1'b0;
    lkp_valid_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      flush_i = (i == 3);
      #1;
      checks++; if ({busy_o, ins_ready_o, lkp_ready_o} !== 4'b1000) begin errors++; $display("[TB] FAIL flush_busy_%0d: got %b expected 1000", i, {busy_o, ins_ready_o, lkp_ready_o}); end
      step();
    end
    flush_i     = 1'b0;
    lkp_valid_i = 2'b00;
    #1;
    checks++; if ({busy_o, ins_ready_o} !== 2'b01) begin errors++; $display("[TB] FAIL flush_done: got %b expected 01", {busy_o, ins_ready_o}); end
    checks++; if (count_o !== CW'(0)) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", count_o); end
    do_lookup(0, 32'h6005);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o} !== 3'b010) begin errors++; $display("[TB] FAIL flush_miss: got %b expected 010", {lkp_rsp_valid_o, lkp_hit_o}); end
    do_insert(32'h20, 32'h10);
    checks++; if ({ins_err_o, count_o} !== {1'b1, CW'(0)}) begin errors++; $display("[TB] FAIL bad_insert: got err=%0b count=%0d expected err=1 count=0", ins_err_o, count_o); end
    step();
    checks++; if (ins_err_o !== 1'b0) begin errors++; $display("[TB] FAIL bad_insert_pulse: got %0b expected 0", ins_err_o); end
    do_lookup(1, 32'h18);
    checks++; if ({lkp_rsp_valid_o, lkp_hit_o, lkp_first_o} !== 4'b1000) begin errors++; $display("[TB] FAIL bad_not_written: got %b expected 1000", {lkp_rsp_valid_o, lkp_hit_o, lkp_first_o}); end
    do_insert(32'h7000, 32'h7000);
    do_lookup(0, 32'h7000);
    checks++; if ({count_o, lkp_hit_o} !== {CW'(1), 1'b1}) begin errors++; $display("[TB] FAIL post_flush_insert: got count=%0d hit=%0b expected count=1 hit=1", count_o, lkp_hit_o); end
  endtask

  initial begin
    test_reset();
    test_basic_lookup();
    test_wrap();
    test_round_robin();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
